// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, T-state enum, IR field offsets.
// No logic; pure declarations.
// Imported by alu_seq_decode and alu_op_sequencer.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Instruction register field positions (LSB of each field)
  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T3,
    S_T4,
    S_T5,
    S_T6
  } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Opcode classifier: legal / unary (NEG, NOT) / wide (MUL, DIV).
// Latency: combinational.
// Optional MUL/DIV support enabled by ALU_SEQ_MULDIV_EN; otherwise MUL/DIV decode as illegal.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0] op,
  output logic       legal,
  output logic       unary,
  output logic       wide
);

  // Classify the opcode; unknown codes fall through as illegal
  always_comb begin
    legal = 1'b0;
    unary = 1'b0;
    wide  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: legal = 1'b1;
      OP_NEG, OP_NOT: begin
        legal = 1'b1;
        unary = 1'b1;
      end
      OP_MUL, OP_DIV: begin
`ifdef ALU_SEQ_MULDIV_EN
        legal = 1'b1;
        wide  = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// T-state control sequencer for register-register ALU instructions (ALU_SEQ_MULDIV_EN adds MUL/DIV).
// Latency accept->done: 3 cycles, 4+MD_WAIT for MUL/DIV; illegal_op one cycle after accept.
// Backpressure: instr_ready only in IDLE; source must hold instr_valid while busy.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int MD_WAIT = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_word,
  output logic [4:0]        alu_opcode,
  output logic [REG_AW-1:0] rf_sel,
  output logic              rf_out,
  output logic              rf_in,
  output logic              y_in,
  output logic              z_in,
  output logic              zlo_out,
  output logic              zhi_out,
  output logic              lo_in,
  output logic              hi_in,
  output logic              done,
  output logic              illegal_op
);

  state_t            state, state_nxt;
  logic [4:0]        ir_op;
  logic [REG_AW-1:0] ir_ra, ir_rb, ir_rc;
  logic              ir_unary, ir_wide;
  logic              illegal_q;
  logic              dec_legal, dec_unary, dec_wide;
  logic              accept;

  assign instr_ready = (state == S_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign illegal_op  = illegal_q;

  alu_seq_decode u_decode (
    .op    (instr_word[OP_LSB +: 5]),
    .legal (dec_legal),
    .unary (dec_unary),
    .wide  (dec_wide)
  );

  // Capture the instruction and its class on transfer; flag rejected opcodes for one cycle
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ir_op     <= '0;
      ir_ra     <= '0;
      ir_rb     <= '0;
      ir_rc     <= '0;
      ir_unary  <= 1'b0;
      ir_wide   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !dec_legal;
      if (accept) begin
        ir_op    <= instr_word[OP_LSB +: 5];
        ir_ra    <= instr_word[RA_LSB +: REG_AW];
        ir_rb    <= instr_word[RB_LSB +: REG_AW];
        ir_rc    <= instr_word[RC_LSB +: REG_AW];
        ir_unary <= dec_unary;
        ir_wide  <= dec_wide;
      end
    end
  end

  // State register; clr forces IDLE so every strobe decoded from state drops at once
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic [3:0] wait_cnt;

  // MUL/DIV dwell counter: loaded in T3, counts down while holding T4
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wait_cnt <= '0;
    end else if (state == S_T3) begin
      wait_cnt <= ir_wide ? 4'(MD_WAIT) : 4'd0;
    end else if (state == S_T4 && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end
`endif

  // Next-state and per-T-state strobe decode
  always_comb begin
    state_nxt  = state;
    alu_opcode = '0;
    rf_sel     = '0;
    rf_out     = 1'b0;
    rf_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    zlo_out    = 1'b0;
    zhi_out    = 1'b0;
    lo_in      = 1'b0;
    hi_in      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && dec_legal) state_nxt = S_T3;
      end
      S_T3: begin
        alu_opcode = ir_op;
        // unary ops spend T3 as a bubble so every op has the same front-end timing
        if (!ir_unary) begin
          rf_sel = ir_rb;
          rf_out = 1'b1;
          y_in   = 1'b1;
        end
        state_nxt = S_T4;
      end
      S_T4: begin
        alu_opcode = ir_op;
        rf_sel     = ir_unary ? ir_rb : ir_rc;
        rf_out     = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        if (wait_cnt == 4'd0) begin
          z_in      = 1'b1;
          state_nxt = S_T5;
        end
`else
        z_in      = 1'b1;
        state_nxt = S_T5;
`endif
      end
      S_T5: begin
        zlo_out = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        if (ir_wide) begin
          lo_in     = 1'b1;
          state_nxt = S_T6;
        end else
`endif
        begin
          rf_sel    = ir_ra;
          rf_in     = 1'b1;
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_T6: begin
`ifdef ALU_SEQ_MULDIV_EN
        zhi_out = 1'b1;
        hi_in   = 1'b1;
        done    = 1'b1;
`endif
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifndef ALU_SEQ_MULDIV_EN
  // ir_wide is only consumed when MUL/DIV sequencing is built in
  logic unused_wide;
  assign unused_wide = ir_wide;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: per-cycle trace model plus directed literal checks.
// Model predicts accept timing itself and queues the expected output vector for each following cycle.
// Covers ALU_SEQ_MULDIV_EN both ways via the same macro.
module tb_alu_op_sequencer;

  localparam int MD_WAIT = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [4:0]  alu_opcode;
  logic [3:0]  rf_sel;
  logic        rf_out, rf_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, done, illegal_op;

  alu_op_sequencer #(.REG_AW(4), .MD_WAIT(MD_WAIT)) dut (
    .clk         (clk),
    .clr         (clr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_word  (instr_word),
    .alu_opcode  (alu_opcode),
    .rf_sel      (rf_sel),
    .rf_out      (rf_out),
    .rf_in       (rf_in),
    .y_in        (y_in),
    .z_in        (z_in),
    .zlo_out     (zlo_out),
    .zhi_out     (zhi_out),
    .lo_in       (lo_in),
    .hi_in       (hi_in),
    .done        (done),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic [4:0] op;
    logic [3:0] sel;
    logic       ro, ri, yi, zi, zlo, zhi, lo, hi, dn, ill;
  } ov_t;

  int  n_chk  = 0;
  int  n_fail = 0;
  int  accepts = 0;
  int  rfin_cnt = 0;
  ov_t exp_q[$];
  ov_t snap[16];
  int  lat;
  ov_t cmp_e, cmp_a;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ov_t sample();
    ov_t v;
    v.rdy = instr_ready; v.op = alu_opcode; v.sel = rf_sel;
    v.ro = rf_out; v.ri = rf_in; v.yi = y_in; v.zi = z_in;
    v.zlo = zlo_out; v.zhi = zhi_out; v.lo = lo_in; v.hi = hi_in;
    v.dn = done; v.ill = illegal_op;
    return v;
  endfunction

  function automatic ov_t idle_v();
    ov_t v = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  // Expected T-state trace of one accepted instruction, derived from the op class
  task automatic push_trace(input logic [31:0] w);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit bin, un, wd;
    ov_t v;
    op = w[31:27]; ra = w[26:23]; rb = w[22:19]; rc = w[18:15];
    bin = (op >= 5'd3 && op <= 5'd11);
    un  = (op == 5'd17 || op == 5'd18);
    wd  = (op == 5'd15 || op == 5'd16);
`ifndef ALU_SEQ_MULDIV_EN
    wd = 1'b0;
`endif
    if (!(bin || un || wd)) begin
      v = idle_v(); v.ill = 1'b1; exp_q.push_back(v);
      return;
    end
    v = '0; v.op = op;
    if (!un) begin v.sel = rb; v.ro = 1'b1; v.yi = 1'b1; end
    exp_q.push_back(v);
    if (wd) for (int i = 0; i < MD_WAIT; i++) begin
      v = '0; v.op = op; v.sel = rc; v.ro = 1'b1; exp_q.push_back(v);
    end
    v = '0; v.op = op; v.sel = un ? rb : rc; v.ro = 1'b1; v.zi = 1'b1;
    exp_q.push_back(v);
    v = '0; v.zlo = 1'b1;
    if (wd) v.lo = 1'b1;
    else begin v.sel = ra; v.ri = 1'b1; v.dn = 1'b1; end
    exp_q.push_back(v);
    if (wd) begin
      v = '0; v.zhi = 1'b1; v.hi = 1'b1; v.dn = 1'b1; exp_q.push_back(v);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (clr) begin
      exp_q.delete();
      cmp_e = idle_v();
    end else if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
    end else begin
      cmp_e = idle_v();
    end
    cmp_a = sample();
    check("cycle_outputs", 64'(cmp_a), 64'(cmp_e));
    if (!clr) begin
      if (rf_in) rfin_cnt++;
      if (cmp_e.rdy && instr_valid) begin
        accepts++;
        push_trace(instr_word);
      end
    end
  end

  // Issue one instruction, record per-cycle snapshots until done (bounded)
  task automatic run_one(input logic [31:0] w);
    int n;
    @(posedge clk); #1;
    instr_word = w; instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    lat = 1;
    snap[1] = sample();
    while (!done && lat < 15) begin
      @(posedge clk); #1;
      lat++;
      snap[lat] = sample();
    end
  endtask

  task automatic run_illegal(input string nm, input logic [31:0] w);
    @(posedge clk); #1;
    instr_word = w; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check({nm, "_pulse"}, 64'(illegal_op), 64'd1);
    check({nm, "_ready"}, 64'(instr_ready), 64'd1);
    check({nm, "_nostrobe"}, 64'({rf_out, rf_in, y_in, z_in, alu_opcode}), 64'd0);
    @(posedge clk); #1;
    check({nm, "_onecycle"}, 64'(illegal_op), 64'd0);
  endtask

  initial begin : stim
    logic [31:0] tbl[4];
    int acc0, rf0;
    clr = 1'b1; instr_valid = 1'b0; instr_word = '0;
    #2;
    check("reset_ready", 64'(instr_ready), 64'd1);
    check("reset_outputs", 64'({alu_opcode, rf_sel, rf_out, rf_in, y_in, z_in, done, illegal_op}), 64'd0);
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;

    // ADD R3,R1,R2
    run_one(mk(5'b00011, 4'd3, 4'd1, 4'd2));
    check("add_latency", 64'(lat), 64'd3);
    check("add_t3_sel", 64'(snap[1].sel), 64'd1);
    check("add_t3_yin", 64'({snap[1].ro, snap[1].yi}), 64'b11);
    check("add_t4_sel", 64'(snap[2].sel), 64'd2);
    check("add_t4_op", 64'(snap[2].op), 64'd3);
    check("add_t4_zin", 64'(snap[2].zi), 64'd1);
    check("add_t5_sel", 64'(snap[3].sel), 64'd3);
    check("add_t5_rfin", 64'({snap[3].ri, snap[3].zlo}), 64'b11);

    // NEG R5,R4
    run_one(mk(5'b10001, 4'd5, 4'd4, 4'd0));
    check("neg_latency", 64'(lat), 64'd3);
    check("neg_t3_bubble", 64'({snap[1].ro, snap[1].yi, snap[1].zi}), 64'd0);
    check("neg_t4_sel", 64'(snap[2].sel), 64'd4);
    check("neg_t4_op", 64'(snap[2].op), 64'd17);
    check("neg_t5_sel", 64'(snap[3].sel), 64'd5);

    // Mixed ops including Ra==Rb and Ra==Rc
    tbl[0] = mk(5'b00101, 4'd1, 4'd1, 4'd2);
    tbl[1] = mk(5'b00111, 4'd9, 4'd8, 4'd9);
    tbl[2] = mk(5'b01011, 4'd15, 4'd14, 4'd13);
    tbl[3] = mk(5'b10010, 4'd0, 4'd12, 4'd7);
    foreach (tbl[i]) begin
      run_one(tbl[i]);
      check("mixed_latency", 64'(lat), 64'd3);
    end

    // MUL R6,R7
    rf0 = rfin_cnt;
`ifdef ALU_SEQ_MULDIV_EN
    run_one(mk(5'b01111, 4'd0, 4'd6, 4'd7));
    check("mul_latency", 64'(lat), 64'd6);
    check("mul_zin_wait", 64'({snap[2].zi, snap[3].zi, snap[4].zi}), 64'b001);
    check("mul_t5", 64'({snap[5].zlo, snap[5].lo, snap[5].ri}), 64'b110);
    check("mul_t6", 64'({snap[6].zhi, snap[6].hi, snap[6].dn}), 64'b111);
    check("mul_no_rfin", 64'(rfin_cnt - rf0), 64'd0);
`else
    run_illegal("mul_disabled", mk(5'b01111, 4'd0, 4'd6, 4'd7));
    run_illegal("div_disabled", mk(5'b10000, 4'd1, 4'd2, 4'd3));
`endif

    run_illegal("illegal_11111", mk(5'b11111, 4'd1, 4'd2, 4'd3));
    run_illegal("illegal_00000", mk(5'b00000, 4'd1, 4'd2, 4'd3));

    // clr during T4 of SUB
    rf0 = rfin_cnt;
    @(posedge clk); #1;
    instr_word = mk(5'b00100, 4'd1, 4'd2, 4'd3); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("sub_t4_zin", 64'(z_in), 64'd1);
    #1 clr = 1'b1;
    #1;
    check("clr_strobes", 64'({alu_opcode, rf_sel, rf_out, rf_in, y_in, z_in, zlo_out,
                              zhi_out, lo_in, hi_in, done}), 64'd0);
    check("clr_ready", 64'(instr_ready), 64'd1);
    @(posedge clk); #1 clr = 1'b0;
    repeat (4) @(posedge clk);
    check("clr_no_writeback", 64'(rfin_cnt - rf0), 64'd0);
    run_one(mk(5'b00011, 4'd3, 4'd1, 4'd2));
    check("post_clr_add_latency", 64'(lat), 64'd3);

    // instr_valid held continuously for 16 cycles
    @(posedge clk); #1;
    acc0 = accepts;
    instr_word = mk(5'b00011, 4'd2, 4'd4, 4'd6); instr_valid = 1'b1;
    repeat (16) @(posedge clk);
    #1 instr_valid = 1'b0;
    check("stream_accepts", 64'(accepts - acc0), 64'd4);
    repeat (6) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
